// File: rtl/alu_seq_ctrl_if.sv
// Instruction, ALU and write-back signals of the alu_seq_ctrl execute-stage sequencer.
// The master modport is the sequencer; the slave modport is the instruction source, ALU and write-back sink.
interface alu_seq_ctrl_if #(
  parameter int W        = 8,
  parameter int MEM_SIZE = 8
);
  logic                instr_valid;
  logic                instr_ready;
  logic [15:0]         instr;
  logic [3:0]          alu_opcode;
  logic [W-1:0]        alu_operand_A;
  logic [W-1:0]        alu_operand_B;
  logic [MEM_SIZE-1:0] alu_memory_address;
  logic [W-1:0]        alu_result;
  logic [2:0]          alu_flag;
  logic                wb_valid;
  logic [1:0]          wb_rd;
  logic [W-1:0]        wb_data;
  logic [2:0]          flags_q;
  logic                busy;

  modport master (
    input  instr_valid, instr, alu_result, alu_flag,
    output instr_ready, alu_opcode, alu_operand_A, alu_operand_B,
           alu_memory_address, wb_valid, wb_rd, wb_data, flags_q, busy
  );

  modport slave (
    output instr_valid, instr, alu_result, alu_flag,
    input  instr_ready, alu_opcode, alu_operand_A, alu_operand_B,
           alu_memory_address, wb_valid, wb_rd, wb_data, flags_q, busy
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Execute-stage sequencer: IDLE -> ISSUE -> WB around a combinational ALU, with a 4-entry register file.
// Optional macro ALU_SEQ_PIPE_EN: also accept in WB, giving one instruction every two cycles.
module alu_seq_ctrl #(
  parameter int W        = 8,
  parameter int MEM_SIZE = 8
) (
  input  logic           clk,
  input  logic           rst,
  alu_seq_ctrl_if.master bus
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WB} state_t;

  localparam int FN = 0;
  localparam int FZ = 1;
  localparam int FC = 2;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_MOV1 = 4'h1;
  localparam logic [3:0] OP_LDI  = 4'h2;
  localparam logic [3:0] OP_MOV3 = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_CMP  = 4'h7;
  localparam logic [3:0] OP_ADDI = 4'hC;
  localparam logic [3:0] OP_SUBI = 4'hD;
  localparam logic [3:0] OP_CMPI = 4'hF;

  state_t       state;
  logic [W-1:0] regs [4];
  logic [3:0]   op_q;
  logic [1:0]   rd_q;

  logic [3:0]   op;
  logic [1:0]   rd;
  logic [1:0]   rs;
  logic [W-1:0] imm;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         accept;

  assign op  = bus.instr[15:12];
  assign rd  = bus.instr[11:10];
  assign rs  = bus.instr[9:8];
  assign imm = bus.instr[W-1:0];

  function automatic logic is_imm_op(input logic [3:0] o);
    return o inside {4'hC, 4'hD, 4'hE, 4'hF, 4'h9, 4'hB};
  endfunction

  function automatic logic is_reg_op(input logic [3:0] o);
    return o inside {4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hA};
  endfunction

  function automatic logic writes_rd(input logic [3:0] o);
    return !(o == OP_NOP || o == OP_CMP || o == OP_CMPI);
  endfunction

`ifdef ALU_SEQ_PIPE_EN
  // The register file is already written at the end of ISSUE, so WB can accept without forwarding.
  assign bus.instr_ready = (state == S_IDLE) || (state == S_WB);
`else
  assign bus.instr_ready = (state == S_IDLE);
`endif

  assign bus.busy = (state != S_IDLE);
  assign accept   = bus.instr_valid & bus.instr_ready;

  always_comb begin
    // NOTE: both outputs get a default before any branch, so no latch is inferred.
    op_a = '0;
    op_b = '0;
    if (op == OP_MOV1 || op == OP_MOV3) begin
      op_a = regs[rs];
    end else if (op == OP_LDI) begin
      op_a = imm;
    end else if (is_imm_op(op)) begin
      op_a = regs[rd];
      op_b = imm;
    end else if (is_reg_op(op)) begin
      op_a = regs[rd];
      op_b = regs[rs];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the register file must read as zero after reset, so it is cleared along with the control state.
      for (int i = 0; i < 4; i++) regs[i] <= '0;
      state                  <= S_IDLE;
      op_q                   <= OP_NOP;
      rd_q                   <= '0;
      bus.flags_q            <= '0;
      bus.wb_valid           <= 1'b0;
      bus.wb_rd              <= '0;
      bus.wb_data            <= '0;
      bus.alu_opcode         <= '0;
      bus.alu_operand_A      <= '0;
      bus.alu_operand_B      <= '0;
      bus.alu_memory_address <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every read sees the pre-edge value (rd==rs is safe).
      bus.wb_valid           <= 1'b0;
      bus.alu_opcode         <= '0;
      bus.alu_operand_A      <= '0;
      bus.alu_operand_B      <= '0;
      bus.alu_memory_address <= '0;

      case (state)
        S_IDLE, S_WB: begin
          if (accept) begin
            state                  <= S_ISSUE;
            op_q                   <= op;
            rd_q                   <= rd;
            bus.alu_opcode         <= op;
            bus.alu_operand_A      <= op_a;
            bus.alu_operand_B      <= op_b;
            bus.alu_memory_address <= MEM_SIZE'(imm);
          end else begin
            state <= S_IDLE;
          end
        end

        S_ISSUE: begin
          state <= S_WB;
          if (writes_rd(op_q)) begin
            regs[rd_q]   <= bus.alu_result;
            bus.wb_valid <= 1'b1;
            bus.wb_rd    <= rd_q;
            bus.wb_data  <= bus.alu_result;
          end
          case (op_q)
            OP_ADD, OP_ADDI: bus.flags_q[FC] <= bus.alu_flag[FC];
            OP_SUB, OP_SUBI: bus.flags_q[FN] <= bus.alu_flag[FN];
            OP_CMP, OP_CMPI: begin
              bus.flags_q[FZ] <= bus.alu_flag[FZ];
              bus.flags_q[FC] <= bus.alu_flag[FC];
            end
            default: ;
          endcase
        end

        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: a behavioural ALU, a table of instructions with expected
// write-back and flags, plus back-to-back and mid-ISSUE reset sequences.
module tb_alu_seq_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  alu_seq_ctrl_if #(.W(8), .MEM_SIZE(8)) bus ();

  alu_seq_ctrl #(.W(8), .MEM_SIZE(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // Behavioural ALU: flags [0]=N, [1]=Z, [2]=C; SUB returns magnitude, CMP sets N/C on borrow.
  logic [7:0] a, b, res;
  logic [2:0] fl;
  logic [8:0] sum9;
  assign a = bus.alu_operand_A;
  assign b = bus.alu_operand_B;
  always_comb begin
    sum9 = {1'b0, a} + {1'b0, b};
    res  = '0;
    fl   = '0;
    case (bus.alu_opcode)
      4'h1, 4'h2, 4'h3: res = a;
      4'h4, 4'hC: begin res = sum9[7:0]; fl[2] = sum9[8]; end
      4'h5, 4'hD: begin
        if (a >= b) res = a - b;
        else begin res = b - a; fl[0] = 1'b1; end
      end
      4'h7, 4'hF: begin res = a - b; fl[0] = (a < b); fl[2] = (a < b); end
      4'h6, 4'hE: res = a & b;
      4'h8, 4'h9: res = a | b;
      4'hA, 4'hB: res = a ^ b;
      default: res = '0;
    endcase
    fl[1] = (res == 8'h00);
  end
  assign bus.alu_result = res;
  assign bus.alu_flag   = fl;

  typedef struct {
    string       name;
    logic [15:0] instr;
    bit          wb;
    logic [1:0]  rd;
    logic [7:0]  data;
    logic [2:0]  flags;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string nm, input logic [15:0] i, input bit wb,
                              input logic [1:0] rd, input logic [7:0] d, input logic [2:0] f);
    vec_t v;
    v.name  = nm;
    v.instr = i;
    v.wb    = wb;
    v.rd    = rd;
    v.data  = d;
    v.flags = f;
    return v;
  endfunction

  // One instruction from IDLE: accept, ISSUE, WB, back to IDLE, checking each cycle.
  task automatic run_vec(input vec_t v);
    logic [3:0] exp_op;
    logic [7:0] exp_addr;
    exp_op   = v.instr[15:12];
    exp_addr = v.instr[7:0];
    @(negedge clk);
    check({v.name, ".ready_idle"}, bus.instr_ready, 1);
    bus.instr_valid = 1'b1;
    bus.instr       = v.instr;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    check({v.name, ".busy_issue"}, bus.busy, 1);
    check({v.name, ".ready_issue"}, bus.instr_ready, 0);
    check({v.name, ".opcode_issue"}, bus.alu_opcode, exp_op);
    check({v.name, ".addr_issue"}, bus.alu_memory_address, exp_addr);
    @(negedge clk);
    check({v.name, ".wb_valid"}, bus.wb_valid, v.wb);
    if (v.wb) begin
      check({v.name, ".wb_rd"}, bus.wb_rd, v.rd);
      check({v.name, ".wb_data"}, bus.wb_data, v.data);
    end
    check({v.name, ".flags"}, bus.flags_q, v.flags);
    check({v.name, ".opcode_wb"}, bus.alu_opcode, 0);
`ifdef ALU_SEQ_PIPE_EN
    check({v.name, ".ready_wb"}, bus.instr_ready, 1);
`else
    check({v.name, ".ready_wb"}, bus.instr_ready, 0);
`endif
    @(negedge clk);
    check({v.name, ".wb_valid_idle"}, bus.wb_valid, 0);
    check({v.name, ".busy_idle"}, bus.busy, 0);
  endtask

  vec_t        vecs[17];
  logic [15:0] b2b_instr[3];
  vec_t        b2b_exp[3];
  int          acc[3];
  int          k, w;
  int          exp_gap;

  initial begin
    vecs[0]  = mk("ldi_r1_0f",   16'h240F, 1, 2'd1, 8'h0F, 3'b000);
    vecs[1]  = mk("ldi_r2_f5",   16'h28F5, 1, 2'd2, 8'hF5, 3'b000);
    vecs[2]  = mk("add_r1_r2",   16'h4600, 1, 2'd1, 8'h04, 3'b100);
    vecs[3]  = mk("addi_r1_01",  16'hC401, 1, 2'd1, 8'h05, 3'b000);
    vecs[4]  = mk("subi_r1_09",  16'hD409, 1, 2'd1, 8'h04, 3'b001);
    vecs[5]  = mk("cmpi_r1_04",  16'hF404, 0, 2'd0, 8'h00, 3'b011);
    vecs[6]  = mk("nop",         16'h0000, 0, 2'd0, 8'h00, 3'b011);
    vecs[7]  = mk("ldi_r3_a5",   16'h2CA5, 1, 2'd3, 8'hA5, 3'b011);
    vecs[8]  = mk("mov_r3_r3",   16'h1F00, 1, 2'd3, 8'hA5, 3'b011);
    vecs[9]  = mk("and_r2_r1",   16'h6900, 1, 2'd2, 8'h04, 3'b011);
    vecs[10] = mk("ori_r3_0a",   16'h9C0A, 1, 2'd3, 8'hAF, 3'b011);
    vecs[11] = mk("xor_r3_r2",   16'hAE00, 1, 2'd3, 8'hAB, 3'b011);
    vecs[12] = mk("sub_r3_r1",   16'h5D00, 1, 2'd3, 8'hA7, 3'b010);
    vecs[13] = mk("xori_r1_ff",  16'hB4FF, 1, 2'd1, 8'hFB, 3'b010);
    vecs[14] = mk("mov_r0_r1",   16'h3100, 1, 2'd0, 8'hFB, 3'b010);
    vecs[15] = mk("cmp_r3_r2",   16'h7E00, 0, 2'd0, 8'h00, 3'b000);
    vecs[16] = mk("addi_r0_wrap",16'hC005, 1, 2'd0, 8'h00, 3'b100);

    b2b_instr[0] = 16'h2011;
    b2b_instr[1] = 16'hC022;
    b2b_instr[2] = 16'h1400;
    b2b_exp[0]   = mk("b2b_ldi",  16'h2011, 1, 2'd0, 8'h11, 3'b000);
    b2b_exp[1]   = mk("b2b_addi", 16'hC022, 1, 2'd0, 8'h33, 3'b000);
    b2b_exp[2]   = mk("b2b_mov",  16'h1400, 1, 2'd1, 8'h33, 3'b000);
`ifdef ALU_SEQ_PIPE_EN
    exp_gap = 2;
`else
    exp_gap = 3;
`endif

    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset.ready", bus.instr_ready, 1);
    check("reset.busy", bus.busy, 0);
    check("reset.wb_valid", bus.wb_valid, 0);
    check("reset.wb_data", bus.wb_data, 0);
    check("reset.flags", bus.flags_q, 0);
    check("reset.opcode", bus.alu_opcode, 0);
    check("reset.addr", bus.alu_memory_address, 0);

    for (int i = 0; i < 17; i++) run_vec(vecs[i]);

    // instr_valid held high across three instructions; record accept cycles and write-backs.
    @(negedge clk);
    k = 0;
    w = 0;
    acc[0] = 0; acc[1] = 0; acc[2] = 0;
    bus.instr       = b2b_instr[0];
    bus.instr_valid = 1'b1;
    for (int c = 0; c < 30 && w < 3; c++) begin
      if (bus.wb_valid) begin
        check({b2b_exp[w].name, ".wb_rd"}, bus.wb_rd, b2b_exp[w].rd);
        check({b2b_exp[w].name, ".wb_data"}, bus.wb_data, b2b_exp[w].data);
        w++;
      end
      if (k < 3 && bus.instr_valid && bus.instr_ready) begin
        acc[k] = c;
        k++;
      end
      @(negedge clk);
      if (k < 3) bus.instr = b2b_instr[k];
      else bus.instr_valid = 1'b0;
    end
    bus.instr_valid = 1'b0;
    check("b2b.accepts", k, 3);
    check("b2b.wb_count", w, 3);
    check("b2b.gap01", acc[1] - acc[0], exp_gap);
    check("b2b.gap12", acc[2] - acc[1], exp_gap);
    repeat (2) @(negedge clk);

    // Make flags non-zero, then reset in the middle of ISSUE of ADD R0,R1.
    run_vec(mk("subi_r1_40", 16'hD440, 1, 2'd1, 8'h0D, 3'b001));
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr       = 16'h4100;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    check("rst_mid.busy_issue", bus.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid.wb_valid", bus.wb_valid, 0);
    check("rst_mid.flags", bus.flags_q, 0);
    check("rst_mid.opcode", bus.alu_opcode, 0);
    check("rst_mid.wb_data", bus.wb_data, 0);
    check("rst_mid.busy", bus.busy, 0);
    check("rst_mid.ready", bus.instr_ready, 1);
    @(negedge clk);
    check("rst_mid.wb_valid_after", bus.wb_valid, 0);
    check("rst_mid.ready_after", bus.instr_ready, 1);
    run_vec(mk("rst_mov_r0", 16'h1000, 1, 2'd0, 8'h00, 3'b000));
    run_vec(mk("rst_mov_r1", 16'h1500, 1, 2'd1, 8'h00, 3'b000));
    run_vec(mk("rst_mov_r2", 16'h1A00, 1, 2'd2, 8'h00, 3'b000));
    run_vec(mk("rst_mov_r3", 16'h1F00, 1, 2'd3, 8'h00, 3'b000));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Execute-stage control unit that drives the ALU opcode/operand interface and consumes its result and flag outputs.
- Accepts 16-bit instructions over a valid/ready handshake and reads operands from a local 4-entry register file.
- Issues one ALU operation per instruction, captures the result and the sign/zero/carry flags, and writes back to the register file and a write-back port.

Parameters:
- W, 8, datapath width (matches ALU operand width; immediate field is W bits, so W=8 is the only legal value).
- MEM_SIZE, 8, width of the ALU memory_address port.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  sequencer can accept
- instr  in  16  [15:12] op, [11:10] rd, [9:8] rs, [7:0] imm
- alu_opcode  out  4  to ALU opcode
- alu_operand_A  out  W  to ALU operand_A
- alu_operand_B  out  W  to ALU operand_B
- alu_memory_address  out  MEM_SIZE  imm[MEM_SIZE-1:0] during ISSUE, else 0
- alu_result  in  W  from ALU result
- alu_flag  in  3  from ALU flag, bits [0:2] = N, Z, C
- wb_valid  out  1  one-cycle pulse, write-back occurred
- wb_rd  out  2  destination register
- wb_data  out  W  written value
- flags_q  out  3  registered N, Z, C
- busy  out  1  state != IDLE

Behaviour:
- FSM states: IDLE, ISSUE, WB.
  - IDLE -> ISSUE on instr_valid & instr_ready; instr latched.
  - ISSUE -> WB always.
  - WB -> IDLE.
- instr_ready = (state==IDLE). Accept at edge T; ISSUE in cycle T+1; WB (wb_valid=1) in cycle T+2; ready again in T+3.
- alu_* outputs are registered, valid only in ISSUE; opcode=0000 and operands=0 in all other states.
- ALU is combinational: alu_result and alu_flag are sampled at the end of ISSUE.
- Immediate-form ops: 1100, 1101, 1110, 1111, 1001, 1011 (B=imm). Register-form ops: 0100, 0101, 0110, 0111, 1000, 1010 (B=R[rs]). For both forms, A=R[rd].
- Op decode:
  - 0000 NOP: no write-back, no wb_valid, flags unchanged.
  - 0001 and 0011 MOV: A=R[rs], B=0, R[rd]<=result.
  - 0010 LDI: A=imm, B=0, R[rd]<=result.
  - ADD (0100/1100): R[rd]<=result; flags_q.C<=alu_flag C; N and Z unchanged.
  - SUB (0101/1101): R[rd]<=result (magnitude); flags_q.N<=alu_flag N; Z and C unchanged.
  - AND/OR/XOR (0110/1110, 1000/1001, 1010/1011): R[rd]<=result; flags unchanged.
  - CMP (0111/1111): no register write, no wb_valid; flags_q.Z and flags_q.C <= alu_flag; N unchanged.
- Write-back: register written at the end of ISSUE. wb_valid, wb_rd and wb_data are held for the WB cycle only; wb_data holds the last value between pulses.
- rd==rs is legal: operands are read before the write.
- Arithmetic wrap is modulo 2^W; carry is taken only from alu_flag.
- instr_valid while not ready: ignored; the sender must hold the instruction.
- Reset (any state, including mid-ISSUE):
  - state=IDLE; R0..R3=0; flags_q=000; wb_valid=0; wb_rd=0; wb_data=0; alu_* =0.
  - instr_ready=1 in the cycle after reset deasserts.
  - An in-flight instruction is dropped with no write.

Optional Feature:
- Macro ALU_SEQ_PIPE_EN.
- Defined: instr_ready is also high in WB. Acceptance in WB goes directly to ISSUE, giving throughput of 1 instruction per 2 cycles. No forwarding is needed because the register file is already written.
- Undefined: throughput is 1 instruction per 3 cycles, as specified above.

Test Plan:
- Reset, then LDI R1,0x0F and LDI R2,0xF5 -> wb_valid pulses with (rd=1, 0x0F) and (rd=2, 0xF5); each pulse arrives 2 cycles after acceptance.
- ADD R1,R2 (0x4600) after the loads -> wb_data=0x04, flags_q.C=1; next ADDI R1,#0x01 -> wb_data=0x05, flags_q.C=0.
- SUBI R1,#0x09 with R1=0x05 -> wb_data=0x04, flags_q.N=1; CMPI R1,#0x04 -> no wb_valid, flags_q.Z=1, flags_q.C=0.
- instr_valid held high across 3 back-to-back instructions -> instr_ready low in ISSUE/WB (1 accept per 3 cycles); with ALU_SEQ_PIPE_EN defined -> 1 accept per 2 cycles, same results.
- Assert rst during ISSUE of ADD R0,R1 -> no wb_valid, R0..R3=0, flags_q=000, instr_ready=1 in the cycle after rst deasserts.
- NOP and MOV R3,R3 -> no pulse for the NOP; the MOV pulses with rd=3 and the unchanged value; alu_opcode=0000 outside ISSUE.
